// File: rtl/cic_integ_decim_pkg.sv
// Shared CIC sizing constants and the accumulator width rule.
package cic_pkg;

  localparam int unsigned CIC_IW     = 4;
  localparam int unsigned CIC_STAGES = 3;
  localparam int unsigned CIC_R      = 8;

  // Worst-case growth of an N-stage CIC with unit differential delay
  function automatic int unsigned cic_out_width(input int unsigned iw,
                                                input int unsigned stages,
                                                input int unsigned r);
    return iw + stages * $clog2(r);
  endfunction

  localparam int unsigned CIC_OW = cic_out_width(CIC_IW, CIC_STAGES, CIC_R);

endpackage

// File: rtl/cic_integ_decim_if.sv
// Sample-in / decimated-sample-out bundle of the CIC integrator section.
interface cic_integ_decim_if #(
    parameter int unsigned IW = 4,
    parameter int unsigned OW = 13
);
    logic                 i_valid;
    logic signed [IW-1:0] i_data;
    logic                 o_valid;
    logic signed [OW-1:0] o_data;

    modport master (output i_valid, output i_data, input  o_valid, input  o_data);
    modport slave  (input  i_valid, input  i_data, output o_valid, output o_data);
endinterface

// File: rtl/cic_integ_decim_integrator.sv
// Single wrap-around accumulator stage with clock enable.
module cic_integrator #(
    parameter int unsigned W = 13
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ce,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_acc
);
    logic [W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (i_ce) acc_d = acc_q + i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign o_acc = acc_q;
endmodule

// File: rtl/cic_integ_decim.sv
// CIC integrator cascade followed by a rate-R decimator feeding the comb section.
module cic_integ_decim
    import cic_pkg::*;
#(
    parameter int unsigned IW     = CIC_IW,
    parameter int unsigned OW     = CIC_OW,
    parameter int unsigned STAGES = CIC_STAGES,
    parameter int unsigned R      = CIC_R
) (
    input  logic               i_clk,
    input  logic               i_reset,
    cic_integ_decim_if.slave   bus
);
    localparam int unsigned CW = $clog2(R);

    if (OW < cic_out_width(IW, STAGES, R)) begin : g_ow_chk
        $error("cic_integ_decim: OW too small for IW/STAGES/R");
    end
    if (STAGES < 1) begin : g_stages_chk
        $error("cic_integ_decim: STAGES must be >= 1");
    end
    if (R < 2) begin : g_r_chk
        $error("cic_integ_decim: R must be >= 2");
    end

    logic [OW-1:0] integ [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [OW-1:0] din;
        if (k == 0) begin : g_first
            assign din = {{(OW-IW){bus.i_data[IW-1]}}, bus.i_data};
        end else begin : g_chain
            assign din = integ[k-1];
        end
        cic_integrator #(.W(OW)) u_int (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_ce    (bus.i_valid),
            .i_data  (din),
            .o_acc   (integ[k])
        );
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] o_data_q, o_data_d;
    logic          o_valid_q, o_valid_d;

    // Last stage is sampled pre-edge, so output lags the input by STAGES samples
    always_comb begin
        cnt_d     = cnt_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        if (bus.i_valid) begin
            if (cnt_q == CW'(R - 1)) begin
                cnt_d     = '0;
                o_data_d  = integ[STAGES-1];
                o_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_cic_integ_decim.sv
// Directed bench for cic_integ_decim: default build plus a STAGES=1, R=2, OW=5 build.
module tb_cic_integ_decim;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_integ_decim_if #(.IW(4), .OW(13)) a_if ();
    cic_integ_decim_if #(.IW(4), .OW(5))  b_if ();

    cic_integ_decim #(.IW(4), .OW(13), .STAGES(3), .R(8)) dut_a (
        .i_clk (clk), .i_reset (rst), .bus (a_if.slave)
    );
    cic_integ_decim #(.IW(4), .OW(5), .STAGES(1), .R(2)) dut_b (
        .i_clk (clk), .i_reset (rst), .bus (b_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        a_if.i_valid = 1'b0;
        a_if.i_data  = '0;
        step();
        chk({tag, "_valid"}, int'(a_if.o_valid), 0);
        chk({tag, "_data"},  int'(a_if.o_data), 0);
        rst = 1'b0;
    endtask

    // Impulse on sample 0; accepted every `gap` cycles; strobes on samples 7/15/23
    task automatic run_impulse(input int gap, input string tag);
        int exp_d [3] = '{15, 91, 231};
        int sidx = 0;
        int cyc  = 0;
        int last = -1;
        int k    = 0;
        while (sidx < 24) begin
            a_if.i_valid = (cyc % gap == 0);
            a_if.i_data  = (a_if.i_valid && sidx == 0) ? 4'sd1 : 4'sd0;
            step();
            if (a_if.i_valid && sidx % 8 == 7) begin
                chk($sformatf("%s_strobe%0d", tag, k), int'(a_if.o_valid), 1);
                chk($sformatf("%s_data%0d", tag, k), int'(a_if.o_data), exp_d[k]);
                if (last >= 0)
                    chk($sformatf("%s_spacing%0d", tag, k), cyc - last, 8 * gap);
                last = cyc;
                k++;
            end else begin
                chk($sformatf("%s_quiet_c%0d", tag, cyc), int'(a_if.o_valid), 0);
            end
            if (a_if.i_valid) sidx++;
            cyc++;
        end
        a_if.i_valid = 1'b0;
        a_if.i_data  = '0;
        step();
        step();
        chk({tag, "_held"}, int'(a_if.o_data), 231);
    endtask

    initial begin
        logic [12:0] m0, m1, m2, exp_d, d, c1, c2, c3, y;
        int          mcnt;
        int          x;
        logic        exp_v;

        a_if.i_valid = 1'b0;
        a_if.i_data  = '0;
        b_if.i_valid = 1'b0;
        b_if.i_data  = '0;
        step();
        chk("rst_b_valid", int'(b_if.o_valid), 0);
        chk("rst_b_data",  int'(b_if.o_data), 0);
        do_reset("rst0");

        // 1. impulse, continuous input
        run_impulse(1, "imp");

        // 2. impulse, one accepted sample every 3 cycles
        do_reset("rst1");
        run_impulse(3, "gap");

        // 4. reset after sample 10 of an impulse run, then replay
        do_reset("rst2");
        for (int s = 0; s < 10; s++) begin
            a_if.i_valid = 1'b1;
            a_if.i_data  = (s == 0) ? 4'sd1 : 4'sd0;
            step();
        end
        chk("mid_pre_data", int'(a_if.o_data), 15);
        do_reset("mid_rst");
        step();
        chk("mid_post_valid", int'(a_if.o_valid), 0);
        chk("mid_post_data",  int'(a_if.o_data), 0);
        run_impulse(1, "replay");

        // 5. reset together with a valid sample of 5: sample must be dropped
        rst = 1'b1;
        a_if.i_valid = 1'b1;
        a_if.i_data  = 4'sd5;
        step();
        chk("rstv_valid", int'(a_if.o_valid), 0);
        chk("rstv_data",  int'(a_if.o_data), 0);
        rst = 1'b0;
        run_impulse(1, "rstv");

        // 3. long constant runs: integrators wrap, comb of the output settles to 512*x
        do_reset("rst3");
        m0 = '0; m1 = '0; m2 = '0; mcnt = 0;
        c1 = '0; c2 = '0; c3 = '0; y = '0;
        for (int ph = 0; ph < 2; ph++) begin
            x = (ph == 0) ? 7 : -8;
            for (int s = 0; s < 2000; s++) begin
                a_if.i_valid = 1'b1;
                a_if.i_data  = 4'(x);
                exp_v = (mcnt == 7);
                exp_d = m2;
                m2 = m2 + m1;
                m1 = m1 + m0;
                m0 = m0 + 13'(x);
                mcnt = (mcnt == 7) ? 0 : mcnt + 1;
                step();
                chk($sformatf("wrap%0d_v_s%0d", ph, s), int'(a_if.o_valid), int'(exp_v));
                if (exp_v) begin
                    d = a_if.o_data;
                    chk($sformatf("wrap%0d_d_s%0d", ph, s), int'($signed(d)), int'($signed(exp_d)));
                    y  = d - 13'd3 * c1 + 13'd3 * c2 - c3;
                    c3 = c2; c2 = c1; c1 = d;
                end
            end
            chk($sformatf("wrap%0d_comb", ph), int'($signed(y)), (ph == 0) ? 3584 : -4096);
        end
        a_if.i_valid = 1'b0;

        // 6. STAGES=1, R=2, OW=5 build: strobe every 2nd sample, running count mod 32
        do_reset("rst4");
        for (int s = 0; s < 40; s++) begin
            b_if.i_valid = 1'b1;
            b_if.i_data  = 4'sd1;
            step();
            chk($sformatf("small_v_s%0d", s), int'(b_if.o_valid), s % 2);
            if (s % 2 == 1)
                chk($sformatf("small_d_s%0d", s), int'($unsigned(b_if.o_data)), s % 32);
        end
        b_if.i_valid = 1'b0;
        step();
        chk("small_gap_v", int'(b_if.o_valid), 0);
        chk("small_held",  int'($unsigned(b_if.o_data)), 39 % 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
